// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer and its lane aligner.
// Entry fields are sized from SB_W, so the top's W must match SB_W.
package sb_pkg;

  localparam int SB_W     = 32;
  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic            valid;
    logic [SB_W-1:0] addr;
    logic [SB_W-1:0] data;
    logic [3:0]      byte_en;
  } sb_entry_t;

  function automatic logic size_ok(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/sb_lane_align.sv
// Places sb/sh/sw store data onto byte lanes and builds the byte enables.
// Latency: combinational.
// Backpressure: none; unsupported sizes produce zero enables.
module sb_lane_align
  import sb_pkg::*;
#(
  parameter int W = SB_W
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   addr_lo,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] adata,
  output logic [3:0]   byte_en
);

  always_comb begin
    adata   = '0;
    byte_en = '0;
    case (funct3)
      F3_SB: begin
        byte_en = 4'b0001 << addr_lo;
        adata   = {4{wdata[7:0]}};
      end
      F3_SH: begin
        // addr_lo[0] is ignored for halfwords
        byte_en = 4'b0011 << {addr_lo[1], 1'b0};
        adata   = {2{wdata[15:0]}};
      end
      F3_SW: begin
        byte_en = 4'b1111;
        adata   = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store write buffer between MEM and data memory; STORE_MERGE_EN enables youngest-entry merging.
// Latency: a store accepted at edge N is presented on MemReq in cycle N+1.
// Backpressure: StallSB when full (judged on registered count) or when a load hits a pending word.
module store_buffer
  import sb_pkg::*;
#(
  parameter int W     = SB_W,
  parameter int DEPTH = SB_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MemWriteM,
  input  logic         MemReadM,
  input  logic [2:0]   Funct3M,
  input  logic [W-1:0] ALUResultM,
  input  logic [W-1:0] WriteDataM,
  output logic         StallSB,
  output logic         SBEmpty,
  output logic         MemReq,
  input  logic         MemAck,
  output logic [W-1:0] MemAddr,
  output logic [W-1:0] MemWData,
  output logic [3:0]   MemByteEn
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t     q [DEPTH];
  logic [PW-1:0] head, tail, young;
  logic [PW:0]   count;

  logic [W-1:0]  waddr, adata, lane_mask;
  logic [3:0]    abe;
  logic          wr_ok, full, push, pop, merge, hit, conflict;

  sb_lane_align #(.W(W)) u_align (
    .funct3  (Funct3M),
    .addr_lo (ALUResultM[1:0]),
    .wdata   (WriteDataM),
    .adata   (adata),
    .byte_en (abe)
  );

  assign waddr = {ALUResultM[W-1:2], 2'b00};
  assign wr_ok = MemWriteM && size_ok(Funct3M);
  assign full  = (count == (PW+1)'(DEPTH));
  assign young = tail - 1'b1;

`ifdef STORE_MERGE_EN
  // count>1 guarantees the youngest entry is not the head being presented
  assign merge = wr_ok && (count > (PW+1)'(1)) && q[young].valid && (q[young].addr == waddr);
`else
  assign merge = 1'b0;
`endif

  assign push = wr_ok && !full && !merge;
  assign pop  = MemReq && MemAck;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (q[i].valid && (q[i].addr == waddr))
        hit = 1'b1;
    lane_mask = '0;
    for (int b = 0; b < 4; b++)
      lane_mask[8*b +: 8] = {8{abe[b]}};
  end

  assign conflict = MemReadM && hit;
  assign StallSB  = (wr_ok && full && !merge) || conflict;
  assign SBEmpty  = (count == '0);
  assign MemReq   = (count != '0);

  assign MemAddr   = MemReq ? q[head].addr    : '0;
  assign MemWData  = MemReq ? q[head].data    : '0;
  assign MemByteEn = MemReq ? q[head].byte_en : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else begin
      if (push) begin
        q[tail] <= '{valid: 1'b1, addr: waddr, data: adata, byte_en: abe};
        tail    <= tail + 1'b1;
      end
      if (merge) begin
        q[young].data    <= (q[young].data & ~lane_mask) | (adata & lane_mask);
        q[young].byte_en <= q[young].byte_en | abe;
      end
      if (pop) begin
        q[head].valid <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed cases followed by random traffic.
// Expected drain entries are queued at issue and checked by a separate drain monitor.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteM, MemReadM, MemAck;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallSB, SBEmpty, MemReq;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemByteEn;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  store_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallSB    (StallSB),
    .SBEmpty    (SBEmpty),
    .MemReq     (MemReq),
    .MemAck     (MemAck),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemByteEn  (MemByteEn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Lane model: access of sz bytes sits at the address rounded down to sz,
  // and every lane carries the store byte (lane mod sz).
  function automatic void align(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] od, output logic [3:0] obe, output bit ok);
    int sz, off;
    ok = 1'b1;
    case (f3)
      3'd0:    sz = 1;
      3'd1:    sz = 2;
      3'd2:    sz = 4;
      default: begin sz = 1; ok = 1'b0; end
    endcase
    od  = '0;
    obe = '0;
    if (ok) begin
      off = (int'(a[1:0]) / sz) * sz;
      for (int i = 0; i < 4; i++) begin
        od[8*i +: 8] = d[8*(i % sz) +: 8];
        if (i >= off && i < off + sz) obe[i] = 1'b1;
      end
    end
  endfunction

  // Called just after a rising edge; drives one cycle of MEM-stage inputs.
  task automatic step(input bit wr, input bit rd, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d, input bit ack);
    logic [31:0] od, wa;
    logic [3:0]  obe;
    bit          ok, merge, hit, exp_stall;
    ent_t        e;
    MemWriteM  = wr;
    MemReadM   = rd;
    Funct3M    = f3;
    ALUResultM = a;
    WriteDataM = d;
    MemAck     = ack;
    #1;
    wa = {a[31:2], 2'b00};
    align(f3, a, d, od, obe, ok);
    merge = 1'b0;
`ifdef STORE_MERGE_EN
    if (wr && ok && sbq.size() >= 2 && sbq[sbq.size()-1].addr == wa) merge = 1'b1;
`endif
    hit = 1'b0;
    foreach (sbq[i]) if (sbq[i].addr == wa) hit = 1'b1;
    exp_stall = (wr && ok && sbq.size() == DEPTH && !merge) || (rd && hit);
    chk("stall", {31'd0, StallSB}, {31'd0, exp_stall});
    chk("empty", {31'd0, SBEmpty}, {31'd0, sbq.size() == 0});
    chk("memreq", {31'd0, MemReq}, {31'd0, sbq.size() != 0});
    if (sbq.size() == 0) chk("idle_bus", MemAddr | MemWData | {28'd0, MemByteEn}, 32'd0);
    if (merge) begin
      e = sbq[sbq.size()-1];
      for (int i = 0; i < 4; i++) if (obe[i]) e.data[8*i +: 8] = od[8*i +: 8];
      e.be = e.be | obe;
      sbq[sbq.size()-1] = e;
    end else if (wr && ok && sbq.size() < DEPTH) begin
      e.addr = wa; e.data = od; e.be = obe;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ack);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, ack);
  endtask

  task automatic do_reset();
    rst = 1'b1; MemWriteM = 1'b0; MemReadM = 1'b0; MemAck = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    chk("reset_memreq", {31'd0, MemReq}, 32'd0);
    chk("reset_empty", {31'd0, SBEmpty}, 32'd1);
    chk("reset_bus", MemAddr | MemWData | {28'd0, MemByteEn}, 32'd0);
  endtask

  // Drain monitor: a handshake this cycle retires the oldest expected entry.
  always @(negedge clk) begin : drain_mon
    ent_t e;
    if (!rst && MemReq && MemAck) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL drain_extra: got addr %h expected no request", MemAddr);
      end else begin
        e = sbq.pop_front();
        chk("drain_addr", MemAddr, e.addr);
        chk("drain_data", MemWData, e.data);
        chk("drain_be", {28'd0, MemByteEn}, {28'd0, e.be});
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; MemWriteM = 1'b0; MemReadM = 1'b0; Funct3M = 3'd0;
    ALUResultM = '0; WriteDataM = '0; MemAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_stall", {31'd0, StallSB}, 32'd0);

    // single sw, one-cycle latency, then drained
    step(1, 0, 3'd2, 32'h100, 32'hDEADBEEF, 1);
    chk("sw_addr", MemAddr, 32'h100);
    chk("sw_data", MemWData, 32'hDEADBEEF);
    chk("sw_be", {28'd0, MemByteEn}, 32'hF);
    idle(1);
    chk("sw_empty_after", {31'd0, SBEmpty}, 32'd1);

    step(1, 0, 3'd0, 32'h203, 32'h12, 0);
    chk("sb_addr", MemAddr, 32'h200);
    chk("sb_data", MemWData, 32'h12121212);
    chk("sb_be", {28'd0, MemByteEn}, 32'h8);
    idle(1);

    step(1, 0, 3'd1, 32'h102, 32'hABCD, 0);
    chk("sh_addr", MemAddr, 32'h100);
    chk("sh_data", MemWData, 32'hABCDABCD);
    chk("sh_be", {28'd0, MemByteEn}, 32'hC);
    idle(1);

    // fill, stall on the fifth, ack lifts it a cycle later
    for (int k = 0; k < 4; k++) step(1, 0, 3'd2, 32'h1000 + 32'(4*k), $urandom, 0);
    step(1, 0, 3'd2, 32'h1010, 32'h55AA55AA, 0);
    chk("full_stall", {31'd0, StallSB}, 32'd1);
    step(1, 0, 3'd2, 32'h1010, 32'h55AA55AA, 1);
    step(1, 0, 3'd2, 32'h1010, 32'h55AA55AA, 0);
    repeat (6) idle(1);

    // load conflict on a pending word
    step(1, 0, 3'd2, 32'h300, 32'h01020304, 0);
    step(0, 1, 3'd2, 32'h302, 32'd0, 0);
    step(0, 1, 3'd2, 32'h304, 32'd0, 0);
    step(0, 1, 3'd2, 32'h302, 32'd0, 1);
    step(0, 1, 3'd2, 32'h302, 32'd0, 0);

    // youngest-entry merge candidates
    step(1, 0, 3'd2, 32'h400, 32'hCAFEF00D, 0);
    step(1, 0, 3'd0, 32'h500, 32'h11, 0);
    step(1, 0, 3'd0, 32'h501, 32'h22, 0);
    repeat (5) idle(1);

    // reset with an unacked head
    step(1, 0, 3'd2, 32'h600, 32'h600D600D, 0);
    step(1, 0, 3'd2, 32'h604, 32'h0BAD0BAD, 0);
    do_reset();
    idle(1);

    for (int c = 0; c < 600; c++) begin
      bit wr, rd, ack;
      logic [2:0] f3;
      logic [31:0] a;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        wr  = ($urandom_range(0, 2) == 0);
        rd  = !wr && ($urandom_range(0, 3) == 0);
        f3  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a   = 32'h800 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
        ack = ($urandom_range(0, 1) == 1);
        step(wr, rd, f3, a, $urandom, ack);
      end
    end

    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", sbq.size());
    end
    chk("final_empty", {31'd0, SBEmpty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Four-entry write buffer between the Memory stage and data memory. Accepts the store datapath output (the operand-B forwarded write data, registered into MEM) together with the ALU-computed address. It aligns the data into byte lanes, queues it, and drains it to data memory over a valid/ack handshake. It raises a stall to the hazard unit when a store cannot be accepted, or when a load hits a pending store's word.

## Interface
Parameters:
- W, 32, data and address width.
- DEPTH, 4, number of buffer entries (power of two, ≥2).

Ports:
- Clocking: one clock, `clk`; reset is synchronous and active-high, `rst`.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- MemWriteM  in  1  store in MEM stage this cycle.
- MemReadM  in  1  load in MEM stage this cycle.
- Funct3M  in  3  access size: 000 sb, 001 sh, 010 sw.
- ALUResultM  in  W  byte address of the access.
- WriteDataM  in  W  unaligned store data (low byte/half/word valid).
- StallSB  out  1  to hazard unit: freeze IF/ID/EX/MEM this cycle.
- SBEmpty  out  1  no entries pending (used by fence).
- MemReq  out  1  write request valid to data memory.
- MemAck  in  1  memory accepts current request this cycle.
- MemAddr  out  W  word-aligned write address.
- MemWData  out  W  lane-aligned write data.
- MemByteEn  out  4  byte enables.

## Operation
- Alignment:
  - sb: ByteEn = 4'b0001 << A[1:0]; data = byte replicated ×4.
  - sh: ByteEn = 4'b0011 << {A[1],0}; data = half replicated ×2; A[0] ignored.
  - sw: ByteEn = 4'b1111; A[1:0] ignored.
  - Stored address is {A[W-1:2],2'b00}.
  - Any other Funct3M with MemWriteM: no enqueue, no stall.
- Storage: circular FIFO with head/tail pointers and a Count of 0..DEPTH. Pointers wrap modulo DEPTH.
- Enqueue: when MemWriteM && valid size && Count<DEPTH, at the clock edge.
- Full: MemWriteM && Count==DEPTH gives StallSB=1. Full is judged on the registered Count, so a same-cycle MemAck does not lift the stall.
- Drain: MemReq = (Count!=0), driven from head. The payload is held stable until MemAck. MemAck with MemReq pops head; MemAck without MemReq is ignored.
- Simultaneous push and pop: Count unchanged, both pointers advance.
- Load conflict: MemReadM && any valid entry's word address == {ALUResultM[W-1:2],2'b00} gives StallSB=1. The stall holds until the matching entries drain. No data forwarding.
- StallSB is the OR of the full and conflict conditions, and is combinational from registered state plus the MEM inputs.
- SBEmpty = (Count==0).
- When MemReq=0: MemAddr, MemWData and MemByteEn are driven to 0.

## Timing
- Reset values: Count=0, pointers 0, all entry valids 0, MemReq=0, MemAddr/MemWData/MemByteEn=0, SBEmpty=1, StallSB=0.
- Reset mid-drain discards all entries, including an unacked head; MemReq drops in the cycle after the reset edge.
- Latency: a store accepted at edge N into an empty buffer gives MemReq=1 in cycle N+1, i.e. one cycle.
- With MemAck tied to 1, throughput is one store per cycle.
- The handshake completes on the edge where MemReq && MemAck; the next entry is presented in the following cycle.

## Configuration
- `STORE_MERGE_EN` defined: a store whose word address equals the youngest entry's address merges into that entry.
  - Merge: enables OR'd, new bytes overwrite old lanes. Count is unchanged.
  - Merging is allowed when full, so no full stall occurs in that case.
  - If the youngest entry is the head with MemReq=1, no merge; the store is enqueued normally.
- Undefined: every store takes a new entry.

## Structure
- Package `sb_pkg`:
  - `sb_entry_t` struct: valid, addr, data, byte_en.
  - Funct3 constants F3_SB, F3_SH, F3_SW.
  - DEPTH-derived pointer width.
- Sub-module `sb_lane_align`: combinational Funct3/address/data to aligned data and byte enables. Instantiated once on the enqueue path.

## Test plan
- sw 0xDEADBEEF to 0x100, MemAck=1 → next cycle MemReq=1, MemAddr=0x100, MemWData=0xDEADBEEF, MemByteEn=1111; SBEmpty returns to 1 one cycle later.
- sb 0x12 to 0x203 → MemAddr=0x200, MemByteEn=1000, MemWData=0x12121212.
- sh 0xABCD to 0x102 → MemAddr=0x100, MemByteEn=1100, MemWData=0xABCDABCD.
- MemAck=0, five sw to distinct words → entries 1–4 accepted; StallSB=1 on the fifth; after one MemAck, fifth accepted next cycle and drain order matches issue order.
- Pending sw at 0x300 with MemAck=0, load at 0x302 → StallSB=1 until the 0x300 ack; load at 0x304 → StallSB=0.
- STORE_MERGE_EN with MemAck=0: entries 0x400 (head) and 0x500 pending; sb 0x11 to 0x500, then sb 0x22 to 0x501 → single 0x500 entry with ByteEn=0011, data bytes 0x2211, Count=2.
